bcd_stopwatch_ctrl: RTL and testbench



---
 rtl/bcd_stopwatch_ctrl_if.sv | 30 +++
 rtl/bcd_stopwatch_ctrl.sv | 115 +++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_ctrl_if
// Brief    : Command pulses in, BCD count/display and status out.
// Revision : 1.0
// ============================================================================
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start_stop;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   display;
    logic                  running;
    logic                  lap_hold;
    logic                  overflow;

    modport master (
        output start_stop, clear, lap,
        input  count, display, running, lap_hold, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output count, display, running, lap_hold, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_ctrl
// Brief    : Start/stop/clear/lap stopwatch over cascaded single-edge BCD digits.
// Revision : 1.0
// ============================================================================
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input wire                 clk,
    input wire                 rst_n,
    bcd_stopwatch_ctrl_if.slave bus
);
    localparam int              c_W    = 4 * DIGITS;
    localparam int              c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t           r_state;
    logic [c_PW-1:0]  r_presc;
    logic [c_W-1:0]   r_count;
    logic [c_W-1:0]   r_lap;
    logic             r_lap_hold;
    logic             r_overflow;
    logic             r_running;

    logic             w_tick;
    logic             w_carry;
    logic             w_wrap;
    logic [c_W-1:0]   w_next;

    // A pause edge suppresses the tick even though the pre-edge state is RUN.
    assign w_tick = (r_state == S_RUN) && !bus.start_stop && (r_presc == c_PMAX);

    // Whole-chain ripple resolved combinationally so every digit lands on one edge.
    always_comb begin
        w_carry = w_tick;
        w_next  = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] >= 4'd9) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
        w_wrap = w_carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_count    <= '0;
            r_lap      <= '0;
            r_lap_hold <= 1'b0;
            r_overflow <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.start_stop) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end else begin
                        r_presc <= (r_presc == c_PMAX) ? '0 : r_presc + 1'b1;
                        r_count <= w_next;
                        if (w_wrap) begin
                            r_overflow <= 1'b1;
                        end
                        if (bus.lap) begin
                            if (!r_lap_hold) begin
                                r_lap      <= r_count;
                                r_lap_hold <= 1'b1;
                            end else begin
                                r_lap_hold <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    // Clear outranks start_stop in both IDLE and PAUSE.
                    if (bus.clear) begin
                        r_state    <= S_IDLE;
                        r_presc    <= '0;
                        r_count    <= '0;
                        r_lap      <= '0;
                        r_lap_hold <= 1'b0;
                        r_overflow <= 1'b0;
                        r_running  <= 1'b0;
                    end else if (bus.start_stop) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.count    = r_count;
    assign bus.display  = r_lap_hold ? r_lap : r_count;
    assign bus.running  = r_running;
    assign bus.lap_hold = r_lap_hold;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bcd_stopwatch_ctrl
// Brief    : Directed and randomized checks against an integer stopwatch model.
// Revision : 1.0
// ============================================================================
module tb_bcd_stopwatch_ctrl;
    localparam int D    = 4;
    localparam int P    = 2;
    localparam int MAXV = 10 ** D;
    localparam int W    = 4 * D;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Model: elapsed ticks as an integer, mode 0 idle / 1 run / 2 pause.
    int   m_mode, m_val, m_pre, m_lapv;
    bit   m_hold, m_ovf;

    bcd_stopwatch_ctrl_if #(.DIGITS(D)) bus ();

    bcd_stopwatch_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] tobcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [2*W+2:0] expect_all();
        return {tobcd(m_val), m_hold ? tobcd(m_lapv) : tobcd(m_val),
                m_mode == 1, m_hold, m_ovf};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_val = 0; m_pre = 0; m_lapv = 0; m_hold = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit lp);
        int old;
        if (m_mode == 1) begin
            if (ss) begin
                m_mode = 2;
            end else begin
                old = m_val;
                if (m_pre == P - 1) begin
                    m_pre = 0;
                    m_val = m_val + 1;
                    if (m_val == MAXV) begin
                        m_val = 0;
                        m_ovf = 1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
                if (lp) begin
                    if (!m_hold) begin
                        m_lapv = old;
                        m_hold = 1;
                    end else begin
                        m_hold = 0;
                    end
                end
            end
        end else if (cl) begin
            model_reset();
        end else if (ss) begin
            m_mode = 1;
        end
    endtask

    task automatic cycle(input bit ss, input bit cl, input bit lp);
        bus.start_stop = ss;
        bus.clear      = cl;
        bus.lap        = lp;
        @(posedge clk);
        model_step(ss, cl, lp);
        #1;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.lap        = 1'b0;
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (m_val != target && n < 30000) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
            checks++;
            if (bus.count !== tobcd(m_val)) begin
                errors++;
                $display("FAIL run_count: got %h expected %h", bus.count, tobcd(m_val));
            end
        end
        if (m_val != target) begin
            errors++;
            $display("FAIL run_until_timeout: reached %0d expected %0d", m_val, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.count, bus.display} !== '0) begin
            errors++;
            $display("FAIL reset_count_display: got %h/%h expected 0/0", bus.count, bus.display);
        end
        checks++;
        if ({bus.running, bus.lap_hold, bus.overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000",
                     {bus.running, bus.lap_hold, bus.overflow});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.running !== 1'b1 || bus.count !== 16'h0000) begin
            errors++;
            $display("FAIL start_running: got run=%b cnt=%h expected 1/0000", bus.running, bus.count);
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 16'h0000) begin
            errors++;
            $display("FAIL start_first_edge: got %h expected 0000", bus.count);
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 16'h0001) begin
            errors++;
            $display("FAIL start_first_tick: got %h expected 0001", bus.count);
        end
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 16'h0002) begin
            errors++;
            $display("FAIL start_second_tick: got %h expected 0002", bus.count);
        end
    endtask

    task automatic test_carry();
        run_until(10);
        checks++;
        if (bus.count !== 16'h0010) begin
            errors++;
            $display("FAIL carry_0010: got %h expected 0010", bus.count);
        end
        run_until(99);
        run_until(100);
        checks++;
        if (bus.count !== 16'h0100) begin
            errors++;
            $display("FAIL carry_0100: got %h expected 0100", bus.count);
        end
    endtask

    task automatic test_overflow();
        run_until(MAXV - 1);
        checks++;
        if (bus.count !== 16'h9999 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: got %h ovf=%b expected 9999 ovf=0", bus.count, bus.overflow);
        end
        run_until(0);
        checks++;
        if (bus.count !== 16'h0000 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap: got %h ovf=%b expected 0000 ovf=1", bus.count, bus.overflow);
        end
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b run=%b expected 1/1", bus.overflow, bus.running);
        end
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.count, bus.running, bus.overflow} !== {16'h0000, 2'b00}) begin
            errors++;
            $display("FAIL ovf_clear: got cnt=%h run=%b ovf=%b expected 0000/0/0",
                     bus.count, bus.running, bus.overflow);
        end
    endtask

    task automatic test_lap();
        cycle(1'b1, 1'b0, 1'b0);
        run_until(12);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.lap_hold !== 1'b1 || bus.display !== 16'h0012) begin
            errors++;
            $display("FAIL lap_freeze: got hold=%b disp=%h expected 1/0012", bus.lap_hold, bus.display);
        end
        run_until(15);
        checks++;
        if (bus.display !== 16'h0012 || bus.count !== 16'h0015) begin
            errors++;
            $display("FAIL lap_held: got disp=%h cnt=%h expected 0012/0015", bus.display, bus.count);
        end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.lap_hold !== 1'b0 || bus.display !== tobcd(m_val)) begin
            errors++;
            $display("FAIL lap_release: got hold=%b disp=%h expected 0/%h",
                     bus.lap_hold, bus.display, tobcd(m_val));
        end
    endtask

    task automatic test_pause_clear();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        run_until(7);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.running !== 1'b0 || bus.count !== 16'h0007) begin
            errors++;
            $display("FAIL pause_hold: got run=%b cnt=%h expected 0/0007", bus.running, bus.count);
        end
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.running !== 1'b0 || bus.count !== 16'h0000) begin
            errors++;
            $display("FAIL clear_wins: got run=%b cnt=%h expected 0/0000", bus.running, bus.count);
        end
    endtask

    task automatic test_resume();
        cycle(1'b1, 1'b0, 1'b0);
        run_until(3);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 16'h0003 || bus.lap_hold !== 1'b0) begin
            errors++;
            $display("FAIL pause_lap_ignored: got cnt=%h hold=%b expected 0003/0", bus.count, bus.lap_hold);
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.running !== 1'b1 || bus.count !== 16'h0003) begin
            errors++;
            $display("FAIL resume_edge: got run=%b cnt=%h expected 1/0003", bus.running, bus.count);
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 16'h0004) begin
            errors++;
            $display("FAIL resume_partial: got %h expected 0004", bus.count);
        end
    endtask

    task automatic test_random();
        logic [2*W+2:0] got;
        bit ss, cl, lp;
        for (int n = 0; n < 2000; n++) begin
            ss = ($urandom_range(0, 99) < 6);
            cl = ($urandom_range(0, 99) < 6);
            lp = ($urandom_range(0, 99) < 10);
            cycle(ss, cl, lp);
            got = {bus.count, bus.display, bus.running, bus.lap_hold, bus.overflow};
            checks++;
            if (got !== expect_all()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, got, expect_all());
            end
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        run_until(345);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.lap_hold !== 1'b1 || bus.display !== 16'h0345) begin
            errors++;
            $display("FAIL areset_setup: got hold=%b disp=%h expected 1/0345", bus.lap_hold, bus.display);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.count, bus.display, bus.running, bus.lap_hold, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL areset_immediate: got cnt=%h disp=%h run=%b hold=%b ovf=%b expected all 0",
                     bus.count, bus.display, bus.running, bus.lap_hold, bus.overflow);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.count, bus.display, bus.running, bus.lap_hold} !== '0) begin
            errors++;
            $display("FAIL areset_after: got cnt=%h disp=%h run=%b hold=%b expected all 0",
                     bus.count, bus.display, bus.running, bus.lap_hold);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_carry();
        test_overflow();
        test_lap();
        test_pause_clear();
        test_resume();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
